defuzz_wavg: RTL

- Sugeno-style defuzzifier directly downstream of the 4-rule min stage.
- Takes the four 16-bit rule firing strengths w_nn, w_np, w_pn, w_pp and computes the crisp output u = sum(w_i*C_i) / sum(w_i) against four signed singleton constants.
- Uses a 4-cycle sequential multiply-accumulate followed by an iterative restoring divider.
- Valid/ready handshake on both sides; one transaction in flight at a time.

---
 rtl/defuzz_wavg_if.sv | 24 ++
 rtl/defuzz_wavg.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/defuzz_wavg_if.sv
// Handshake bundle between the rule min stage, the defuzzifier and its consumer.
// The master side supplies rule weights and accepts results; the slave side is the defuzzifier.
interface defuzz_wavg_if;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        w_nn;
  logic [15:0]        w_np;
  logic [15:0]        w_pn;
  logic [15:0]        w_pp;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] u_out;
  logic               w_zero;

  modport master (
    output in_valid, w_nn, w_np, w_pn, w_pp, out_ready,
    input  in_ready, out_valid, u_out, w_zero
  );

  modport slave (
    input  in_valid, w_nn, w_np, w_pn, w_pp, out_ready,
    output in_ready, out_valid, u_out, w_zero
  );
endinterface

// File: rtl/defuzz_wavg.sv
// Sugeno weighted-average defuzzifier: a 4-cycle MAC over the rule singletons,
// followed by a restoring divide of sum(w*C) by sum(w), one quotient bit per cycle.
module defuzz_wavg #(
  parameter logic signed [15:0] C_NN = -16'sd16384,
  parameter logic signed [15:0] C_NP = -16'sd4096,
  parameter logic signed [15:0] C_PN = 16'sd4096,
  parameter logic signed [15:0] C_PP = 16'sd16384
) (
  input logic          clk,
  input logic          rst,
  defuzz_wavg_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, DIV, DONE} state_t;

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic [15:0]        r_wNn, r_wNp, r_wPn, r_wPp;
  logic signed [34:0] r_num;
  logic [17:0]        r_den;
  logic [34:0]        r_quo;
  logic [17:0]        r_rem;
  logic               r_neg;
  logic               r_inReady;
  logic               r_outValid;
  logic signed [15:0] r_uOut;
  logic               r_wZero;

  logic [15:0]        w_wSel;
  logic signed [15:0] w_cSel;
  logic signed [32:0] w_prod;
  logic signed [34:0] w_numNext;
  logic [17:0]        w_denNext;
  logic [34:0]        w_numAbs;
  logic [18:0]        w_remShift;
  logic               w_qBit;
  logic [18:0]        w_remNext;
  logic [34:0]        w_quoSigned;

  // The MAC step counter picks which rule is accumulated this cycle.
  always_comb begin
    w_wSel = r_wNn;
    w_cSel = C_NN;
    case (r_cnt[1:0])
      2'd0: begin w_wSel = r_wNn; w_cSel = C_NN; end
      2'd1: begin w_wSel = r_wNp; w_cSel = C_NP; end
      2'd2: begin w_wSel = r_wPn; w_cSel = C_PN; end
      default: begin w_wSel = r_wPp; w_cSel = C_PP; end
    endcase
  end

  assign w_prod      = $signed({1'b0, w_wSel}) * w_cSel;
  assign w_numNext   = r_num + {{2{w_prod[32]}}, w_prod};
  assign w_denNext   = r_den + {2'b00, w_wSel};
  assign w_numAbs    = w_numNext[34] ? 35'(-w_numNext) : 35'(w_numNext);

  // Dividend bits are shifted out of r_quo as quotient bits are shifted in.
  assign w_remShift  = {r_rem, r_quo[34]};
  assign w_qBit      = (w_remShift >= {1'b0, r_den});
  assign w_remNext   = w_qBit ? (w_remShift - {1'b0, r_den}) : w_remShift;
  assign w_quoSigned = r_neg ? (~r_quo + 35'd1) : r_quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wNn      <= '0;
      r_wNp      <= '0;
      r_wPn      <= '0;
      r_wPp      <= '0;
      r_num      <= '0;
      r_den      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_neg      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_uOut     <= '0;
      r_wZero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_inReady) begin
            r_wNn     <= bus.w_nn;
            r_wNp     <= bus.w_np;
            r_wPn     <= bus.w_pn;
            r_wPp     <= bus.w_pp;
            r_num     <= '0;
            r_den     <= '0;
            r_cnt     <= '0;
            r_inReady <= 1'b0;
            r_state   <= MAC;
          end
        end
        MAC: begin
          r_num <= w_numNext;
          r_den <= w_denNext;
          if (r_cnt == 6'd3) begin
            r_cnt   <= '0;
            r_quo   <= w_numAbs;
            r_neg   <= w_numNext[34];
            r_rem   <= '0;
            r_state <= DIV;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DIV: begin
          // The first DIV cycle doubles as the zero-weight check; cycle 35 only applies the sign.
          if (r_cnt == 6'd0 && r_den == 18'd0) begin
            r_uOut     <= '0;
            r_wZero    <= 1'b1;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else if (r_cnt == 6'd35) begin
            r_uOut     <= w_quoSigned[15:0];
            r_wZero    <= 1'b0;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_rem <= w_remNext[17:0];
            r_quo <= {r_quo[33:0], w_qBit};
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.u_out     = r_uOut;
  assign bus.w_zero    = r_wZero;

endmodule
